c2c_w_arb: RTL
==============

C2C_W_ARB -- requirements
Module: c2c_w_arb

Interface
REQ-001 Parameter RR, default 1: 1 selects round-robin priority; 0 selects fixed priority with m0 highest.
REQ-002 Data width is pipeline::XLEN; sel width is XLEN/8. The block has no width parameter.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 m0  c2c_w.slave  --  requester 0 (store unit); signals m0.we, m0.sel, m0.addr, m0.data in; m0.ack out.
REQ-006 m1  c2c_w.slave  --  requester 1 (second writer, e.g. debug/flush); signals as m0.
REQ-007 s  c2c_w.master  --  shared cache write port; s.we, s.sel, s.addr, s.data out; s.ack in.
REQ-008 busy  output  1  high while a grant is held (state BUSY).
REQ-009 gnt  output  1  index of the currently or most recently granted requester.

Function
REQ-010 Port protocol: a master raises we with stable sel/addr/data and holds them until it sees a one-cycle ack; the slave pulses ack for one cycle per accepted write.
REQ-011 FSM states are IDLE and BUSY; reset state is IDLE.
REQ-012 IDLE: if any mN.we is high, choose a winner, register gnt=winner, and enter BUSY on the next edge. Otherwise stay in IDLE.
REQ-013 Winner selection with RR=1: a single requester wins outright. If both request, the winner is the requester not granted last (prio register; reset value prio points to m0).
REQ-014 Winner selection with RR=0: m0 wins whenever m0.we is high.
REQ-015 In IDLE: s.we=0 and both acks are 0. s.sel, s.addr and s.data are don't-care but driven from m[gnt] (no X).
REQ-016 In BUSY: s.we, s.sel, s.addr and s.data equal m[gnt] combinationally (zero-cycle forward).
REQ-017 In BUSY: m[gnt].ack = s.ack combinationally, and the non-granted ack is 0.
REQ-018 BUSY with s.ack=1: return to IDLE on the next edge and set prio to the other requester (RR=1).
REQ-019 Arbitration latency: a request into an idle arbiter appears on s.we exactly 1 cycle after mN.we rises.
REQ-020 Minimum inter-write gap on s is 1 idle cycle, so back-to-back writes from different requesters complete one per 2+ack-latency cycles.
REQ-021 BUSY with m[gnt].we=0 and s.ack=0 (requester abort): return to IDLE on the next edge; prio is unchanged.
REQ-022 s.ack while IDLE is ignored and is not forwarded to either requester.
REQ-023 Any s.ack in BUSY completes the held write, including an ack in the first BUSY cycle.
REQ-024 The non-granted requester's we may toggle freely during BUSY without affecting s or the state.
REQ-025 No combinational path from s.ack to s.we or to any s output.
REQ-026 busy = (state==BUSY); gnt is registered and holds its value through IDLE.

Reset
REQ-027 On reset_n=0, asynchronously: state=IDLE, gnt=0, prio=m0, busy=0, s.we=0, m0.ack=0, m1.ack=0.
REQ-028 Reset asserted mid-BUSY abandons the transfer without any ack. After release, arbitration restarts from REQ-012 with m0 priority.
REQ-029 The first arbitration decision occurs on the first rising edge after reset_n deasserts.

Verification
REQ-030 m0.we=1 alone, addr=0x100, data=0xDEADBEEF, sel=0xF; s.ack on the 3rd BUSY cycle -> s.we high from cycle+1, s.addr=0x100, m0.ack pulses the same cycle as s.ack, m1.ack stays 0.
REQ-031 RR=1, m0.we and m1.we rise together after reset; each requester drops we after its ack -> grants m0 then m1, and the sequence on s is m0 write, one idle cycle, m1 write.
REQ-032 RR=1, both requesting continuously for 4 writes -> gnt sequence 0,1,0,1; with RR=0 the same stimulus -> gnt stays 0 while m0.we remains high.
REQ-033 s.ack=1 while IDLE with m1.we=0 and m0.we=0 -> no ack on m0 or m1, state stays IDLE.
REQ-034 m1 granted, m1.we drops before ack -> IDLE next cycle, s.we=0, prio unchanged, so the next contention grants m0.
REQ-035 reset_n pulsed low mid-BUSY -> s.we=0 immediately (asynchronously), no ack issued, and gnt=0 after release.

Source files
------------

// File: rtl/c2c_w_arb_if.sv
// rtl/c2c_w_arb_if.sv - pipeline width package and c2c_w write-port interface
package pipeline;
  localparam int XLEN = 32;
endpackage

interface c2c_w;
  import pipeline::*;
  logic              we;
  logic [XLEN/8-1:0] sel;
  logic [XLEN-1:0]   addr;
  logic [XLEN-1:0]   data;
  logic              ack;

  modport master (output we, sel, addr, data, input ack);
  modport slave  (input we, sel, addr, data, output ack);
endinterface

// File: rtl/c2c_w_arb.sv
// rtl/c2c_w_arb.sv - two-requester write-port arbiter (round-robin or fixed priority)
module c2c_w_arb #(
  parameter bit RR = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  c2c_w.slave  m0,
  c2c_w.slave  m1,
  c2c_w.master s,
  output logic busy,
  output logic gnt
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e state_q, state_d;
  logic   gnt_q, gnt_d;
  logic   prio_q, prio_d;
  logic   winner;
  logic   gnt_we;

  // Contention goes to prio (round-robin) or m0 (fixed); a lone requester always wins.
  always_comb begin
    if (m0.we && m1.we) winner = RR ? prio_q : 1'b0;
    else                winner = m1.we && !m0.we;
  end

  assign gnt_we = gnt_q ? m1.we : m0.we;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      prio_q  <= prio_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    prio_d  = prio_q;
    case (state_q)
      IDLE: begin
        if (m0.we || m1.we) begin
          state_d = BUSY;
          gnt_d   = winner;
        end
      end
      BUSY: begin
        if (s.ack) begin
          state_d = IDLE;
          if (RR) prio_d = ~gnt_q;
        end else if (!gnt_we) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // s.ack only reaches the requester acks, never the s-side outputs.
  assign busy   = (state_q == BUSY);
  assign gnt    = gnt_q;
  assign s.we   = busy && gnt_we;
  assign s.sel  = gnt_q ? m1.sel  : m0.sel;
  assign s.addr = gnt_q ? m1.addr : m0.addr;
  assign s.data = gnt_q ? m1.data : m0.data;
  assign m0.ack = busy && !gnt_q && s.ack;
  assign m1.ack = busy &&  gnt_q && s.ack;

endmodule
